// File: rtl/gtx_align_pkg.sv
// Shared types and helpers for the GTX word aligner: FSM state, slip
// direction encoding and the offset-width helper.
package gtx_align_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        VERIFY = 2'd2,
        LOCKED = 2'd3
    } align_state_e;

    typedef enum logic [1:0] {
        SLIP_NONE  = 2'b00,
        SLIP_LATER = 2'b01,
        SLIP_EARLY = 2'b10
    } slip_dir_e;

    function automatic int off_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/gtx_align_barrel.sv
// Sliding 2*W-bit window over consecutive GTX words with a registered
// W-bit extraction at a selectable bit offset (datapath only).
module gtx_align_barrel
    import gtx_align_pkg::*;
#(
    parameter int W     = 32,
    parameter int OFF_W = off_w(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     datain,
    input  logic [OFF_W-1:0] offset,
    output logic [W-1:0]     dataout
);

    logic [2*W-1:0] win;
    logic [OFF_W:0] sel;

    assign sel = {1'b0, offset};

    // Newest word enters at the top; bit 0 of the window is the oldest bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win     <= '0;
            dataout <= '0;
        end else begin
            win     <= {datain, win[2*W-1:W]};
            dataout <= win[sel +: W];
        end
    end

endmodule

// File: rtl/gtx_word_aligner.sv
// Bit-slip word aligner with header search/verify/lock FSM and hysteresis.
// Define GTX_ALIGN_EARLY_SHIFT_EN to enable early slips and bidirectional search.
module gtx_word_aligner
    import gtx_align_pkg::*;
#(
    parameter int               W          = 32,
    parameter int               PAT_W      = 2,
    parameter logic [PAT_W-1:0] PATTERN    = 2'b10,
    parameter int               FRAME_LEN  = 1,
    parameter int               LOCK_CNT   = 16,
    parameter int               UNLOCK_CNT = 4,
    localparam int              OFF_W      = off_w(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     datain,
    input  logic             auto_en,
    input  logic             shift_fr_later,
    input  logic             shift_fr_early,
    output logic [W-1:0]     dataout,
    output logic             d_enb,
    output logic [PAT_W-1:0] PATTERN_o,
    output logic             locked,
    output logic [OFF_W-1:0] slip_offset,
    output logic             hdr_err
);

    localparam int FC_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
    localparam logic [OFF_W-1:0]  OFF_MAX   = OFF_W'(W - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_CNT - 1);

    align_state_e      state, state_nxt;
    slip_dir_e         slip, auto_slip;
    logic [OFF_W-1:0]  offset;
    logic [FC_W-1:0]   frame_cnt, frame_nxt;
    logic [GOOD_W-1:0] good_cnt;
    logic [BAD_W-1:0]  bad_cnt;
    logic              slip_d1, slip_d2;
    logic              eval, match;

    function automatic logic [FC_W-1:0] fc_step(input logic [FC_W-1:0] fc,
                                                input int unsigned     inc);
        int unsigned sum;
        sum = 32'(fc) + inc;
        return FC_W'(sum % FRAME_LEN);
    endfunction

    gtx_align_barrel #(.W(W), .OFF_W(OFF_W)) u_barrel (
        .clk     (clk),
        .rst     (rst),
        .datain  (datain),
        .offset  (offset),
        .dataout (dataout)
    );

    // The two cycles after a slip still carry words taken at the old offset.
    assign eval  = (frame_cnt == '0) && !slip_d1 && !slip_d2;
    assign match = (dataout[PAT_W-1:0] == PATTERN);

`ifdef GTX_ALIGN_EARLY_SHIFT_EN
    localparam int SPAN_W = OFF_W + 1;
    localparam logic [SPAN_W-1:0] SPAN_MAX = SPAN_W'(W);

    slip_dir_e         srch_dir;
    logic [SPAN_W-1:0] srch_span, srch_left;
    logic              srch_run_end;

    assign srch_run_end = (srch_left == SPAN_W'(1)) ||
                          ((srch_left == '0) && (srch_span == SPAN_W'(1)));

    // Search sweeps +1, -2, +3, -4 ... slips around the starting offset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            srch_dir  <= SLIP_LATER;
            srch_span <= SPAN_W'(1);
            srch_left <= '0;
        end else if (!auto_en || state != SEARCH) begin
            srch_dir  <= SLIP_LATER;
            srch_span <= SPAN_W'(1);
            srch_left <= '0;
        end else if (auto_slip != SLIP_NONE) begin
            srch_left <= (srch_left != '0) ? srch_left - 1'b1 : srch_span - 1'b1;
            if (srch_run_end) begin
                srch_dir <= (srch_dir == SLIP_LATER) ? SLIP_EARLY : SLIP_LATER;
                if (srch_span != SPAN_MAX)
                    srch_span <= srch_span + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        slip = SLIP_NONE;
        if (auto_en) begin
            slip = auto_slip;
        end else begin
`ifdef GTX_ALIGN_EARLY_SHIFT_EN
            if (shift_fr_later && !shift_fr_early)
                slip = SLIP_LATER;
            else if (shift_fr_early && !shift_fr_later)
                slip = SLIP_EARLY;
`else
            if (shift_fr_later)
                slip = SLIP_LATER;
`endif
        end
    end

    // A later-slip across W-1 -> 0 re-reads a word, so the frame phase holds.
    always_comb begin
        frame_nxt = fc_step(frame_cnt, 1);
        if (slip == SLIP_LATER && offset == OFF_MAX)
            frame_nxt = frame_cnt;
        else if (slip == SLIP_EARLY && offset == '0)
            frame_nxt = fc_step(frame_cnt, 2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset    <= '0;
            frame_cnt <= '0;
            slip_d1   <= 1'b0;
            slip_d2   <= 1'b0;
        end else begin
            slip_d1   <= (slip != SLIP_NONE);
            slip_d2   <= slip_d1;
            frame_cnt <= frame_nxt;
            case (slip)
                SLIP_LATER: offset <= (offset == OFF_MAX) ? '0 : offset + 1'b1;
                SLIP_EARLY: offset <= (offset == '0) ? OFF_MAX : offset - 1'b1;
                default:    offset <= offset;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!auto_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = SEARCH;
                SEARCH:  if (eval && match)
                             state_nxt = (LOCK_CNT <= 1) ? LOCKED : VERIFY;
                VERIFY:  if (eval)
                             state_nxt = !match ? SEARCH :
                                         (good_cnt == GOOD_LAST) ? LOCKED : VERIFY;
                LOCKED:  if (eval && !match && bad_cnt == BAD_LAST)
                             state_nxt = SEARCH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        auto_slip   = SLIP_NONE;
        locked      = (state == LOCKED);
        d_enb       = (state == LOCKED);
        PATTERN_o   = dataout[PAT_W-1:0];
        slip_offset = offset;
        case (state)
            SEARCH: begin
`ifdef GTX_ALIGN_EARLY_SHIFT_EN
                if (srch_left != '0 || (eval && !match))
                    auto_slip = srch_dir;
`else
                if (eval && !match)
                    auto_slip = SLIP_LATER;
`endif
            end
            VERIFY:  if (eval && !match) auto_slip = SLIP_LATER;
            default: auto_slip = SLIP_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
            hdr_err  <= 1'b0;
        end else begin
            hdr_err <= auto_en && (state == LOCKED) && eval && !match;
            if (!auto_en) begin
                good_cnt <= '0;
                bad_cnt  <= '0;
            end else begin
                case (state)
                    SEARCH:  if (eval && match) good_cnt <= GOOD_W'(1);
                    VERIFY:  if (eval)
                                 good_cnt <= (match && good_cnt != GOOD_LAST) ?
                                             good_cnt + 1'b1 : '0;
                    LOCKED:  if (eval)
                                 bad_cnt <= (!match && bad_cnt != BAD_LAST) ?
                                            bad_cnt + 1'b1 : '0;
                    default: begin
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gtx_word_aligner.sv
// Self-checking bench for gtx_word_aligner: manual-slip vector table, random
// datapath run against a word-history model, and lock/unlock sequences.
module tb_gtx_word_aligner;

    localparam int W = 32;
`ifdef GTX_ALIGN_EARLY_SHIFT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif
    localparam int NRND = 200;

    logic         clk = 1'b0;
    logic         rst, auto_en, later, early;
    logic [W-1:0] datain, dout;
    logic         d_enb, locked, hdr_err;
    logic [1:0]   pat_o;
    logic [4:0]   soff;

    logic         later4, auto4, early4;
    logic [W-1:0] dout4;
    logic         d_enb4, locked4, hdr_err4;
    logic [1:0]   pat_o4;
    logic [4:0]   soff4;

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;   // 0 = good headers, 1 = bad headers, 2 = hold datain

    gtx_word_aligner dut (
        .clk(clk), .rst(rst), .datain(datain), .auto_en(auto_en),
        .shift_fr_later(later), .shift_fr_early(early), .dataout(dout),
        .d_enb(d_enb), .PATTERN_o(pat_o), .locked(locked),
        .slip_offset(soff), .hdr_err(hdr_err)
    );

    gtx_word_aligner #(.FRAME_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .datain(datain), .auto_en(auto4),
        .shift_fr_later(later4), .shift_fr_early(early4), .dataout(dout4),
        .d_enb(d_enb4), .PATTERN_o(pat_o4), .locked(locked4),
        .slip_offset(soff4), .hdr_err(hdr_err4)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] good_word();
        logic [W-1:0] w;
        w = $urandom();
        w[8:0] = 9'b1_0000_0000;   // header 2'b10 at bit 7, quiet bits below
        return w;
    endfunction

    function automatic logic [W-1:0] bad_word();
        logic [W-1:0] w;
        w = $urandom();
        w[8:0] = 9'b0;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (mode == 0)      datain = good_word();
        else if (mode == 1) datain = bad_word();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_lock(input int budget, output int slips, output int since);
        logic [4:0] prev;
        prev  = soff;
        slips = 0;
        since = 0;
        for (int i = 0; i < budget && !locked; i++) begin
            tick();
            if (soff != prev) begin
                slips++;
                since = 0;
                prev  = soff;
            end else begin
                since++;
            end
        end
    endtask

    task automatic count_window(input int n, inout int errs, inout int drops);
        for (int i = 0; i < n; i++) begin
            tick();
            if (hdr_err) errs++;
            if (!locked) drops++;
        end
    endtask

    typedef struct {
        logic l;
        logic e;
        logic a;
        int   exp_off;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [W-1:0]   wq   [NRND+2];
        int             offq [NRND+1];
        logic [2*W-1:0] cat;
        int slips, since, errs, drops, om, fcm;
        logic lat, erl;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1};
        tbl[1] = '{1'b1, 1'b1, 1'b0, EARLY_EN ? 1  : 2};
        tbl[2] = '{1'b0, 1'b1, 1'b0, EARLY_EN ? 0  : 2};
        tbl[3] = '{1'b0, 1'b1, 1'b0, EARLY_EN ? 31 : 2};
        tbl[4] = '{1'b1, 1'b0, 1'b1, EARLY_EN ? 31 : 2};
        tbl[5] = '{1'b1, 1'b0, 1'b0, EARLY_EN ? 0  : 3};
        tbl[6] = '{1'b0, 1'b0, 1'b0, EARLY_EN ? 0  : 3};
        tbl[7] = '{1'b1, 1'b0, 1'b0, EARLY_EN ? 1  : 4};

        rst = 1'b1; auto_en = 1'b0; later = 1'b0; early = 1'b0;
        later4 = 1'b0; auto4 = 1'b0; early4 = 1'b0;
        datain = '0; mode = 0;

        // Reset state
        tick();
        tick();
        check("rst_dataout", 64'(dout), 64'd0);
        check("rst_d_enb", 64'(d_enb), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_offset", 64'(soff), 64'd0);
        check("rst_hdr_err", 64'(hdr_err), 64'd0);
        check("rst_pattern_o", 64'(pat_o), 64'd0);
        rst = 1'b0;

        // Manual slip vector table from offset 0
        for (int i = 0; i < 8; i++) begin
            later   = tbl[i].l;
            early   = tbl[i].e;
            auto_en = tbl[i].a;
            tick();
            check($sformatf("tbl%0d_offset", i), 64'(soff), 64'(tbl[i].exp_off));
            check($sformatf("tbl%0d_d_enb", i), 64'(d_enb), 64'd0);
        end
        later = 1'b0; early = 1'b0; auto_en = 1'b0;

        // Random datapath run: dataout is a W-bit slice of the two previous words
        mode = 2;
        do_reset();
        wq[0] = '0; wq[1] = '0; offq[0] = 0;
        for (int k = 0; k < NRND; k++) begin
            wq[k+2] = $urandom();
            lat = ($urandom_range(0, 3) == 0);
            erl = ($urandom_range(0, 3) == 0);
            om  = offq[k];
            if (EARLY_EN) begin
                if (lat && !erl)      om = (om + 1) % W;
                else if (erl && !lat) om = (om + W - 1) % W;
            end else if (lat) begin
                om = (om + 1) % W;
            end
            offq[k+1] = om;
            datain = wq[k+2];
            later  = lat;
            early  = erl;
            tick();
            cat = {wq[k+1], wq[k]} >> offq[k];
            check($sformatf("rnd%0d_dataout", k), 64'(dout), 64'(cat[W-1:0]));
            check($sformatf("rnd%0d_offset", k), 64'(soff), 64'(offq[k+1]));
        end
        later = 1'b0; early = 1'b0;

        // Header at bit 7: auto search and lock
        mode = 0;
        auto_en = 1'b1;
        do_reset();
        wait_lock(400, slips, since);
        check("lock_locked", 64'(locked), 64'd1);
        check("lock_d_enb", 64'(d_enb), 64'd1);
        check("lock_offset", 64'(soff), 64'd7);
        check("lock_pattern_o", 64'(pat_o), 64'h2);
`ifndef GTX_ALIGN_EARLY_SHIFT_EN
        check("lock_slip_count", 64'(slips), 64'd7);
        check("lock_cycles_after_align", 64'(since), 64'd18);
`endif

        // Three bad headers then a good one: stay locked, twice in a row
        for (int r = 0; r < 2; r++) begin
            errs = 0; drops = 0;
            mode = 1;
            count_window(3, errs, drops);
            mode = 0;
            count_window(10, errs, drops);
            check($sformatf("bad3_hdr_err_r%0d", r), 64'(errs), 64'd3);
            check($sformatf("bad3_unlock_r%0d", r), 64'(drops), 64'd0);
        end

        // Four bad headers: unlock, then relock at the same offset
        errs = 0; drops = 0;
        mode = 1;
        count_window(4, errs, drops);
        mode = 0;
        count_window(6, errs, drops);
        check("bad4_hdr_err", 64'(errs), 64'd4);
        check("bad4_unlocked", 64'(drops > 0), 64'd1);
        wait_lock(200, slips, since);
        check("relock_locked", 64'(locked), 64'd1);
        check("relock_offset", 64'(soff), 64'd7);
        check("relock_slips", 64'(slips), 64'd0);

        // auto_en falling while locked returns to manual mode
        auto_en = 1'b0;
        tick();
        tick();
        check("auto_off_locked", 64'(locked), 64'd0);
        check("auto_off_offset", 64'(soff), 64'd7);

        // Asynchronous reset while verifying
        auto_en = 1'b1;
        do_reset();
        for (int i = 0; i < 300 && soff != 5'd7; i++) tick();
        check("verify_offset", 64'(soff), 64'd7);
        repeat (5) tick();
        check("verify_not_locked", 64'(locked), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_dataout", 64'(dout), 64'd0);
        check("midrst_offset", 64'(soff), 64'd0);
        check("midrst_locked", 64'(locked), 64'd0);
        check("midrst_pattern_o", 64'(pat_o), 64'd0);
        tick();
        rst = 1'b0;
        wait_lock(400, slips, since);
        check("postrst_locked", 64'(locked), 64'd1);
        check("postrst_offset", 64'(soff), 64'd7);

        // FRAME_LEN=4 instance: offset wrap on a later slip holds the frame counter
        auto_en = 1'b0;
        do_reset();
        om = 0; fcm = 0;
        for (int i = 0; i < 40; i++) begin
            lat = (i < 32);
            later4 = lat;
            tick();
            if (lat && om == W - 1) begin
                om = 0;
            end else begin
                if (lat) om = om + 1;
                fcm = (fcm + 1) % 4;
            end
            check($sformatf("fl4_offset_%0d", i), 64'(soff4), 64'(om));
            check($sformatf("fl4_frame_%0d", i), 64'(dut4.frame_cnt), 64'(fcm));
        end
        later4 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
